// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Instruction field layout, R-type opcode and encoder state
//               type, shared by the encoder and the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int R1_MSB  = 27;
    localparam int R1_LSB  = 23;
    localparam int R2_MSB  = 22;
    localparam int R2_LSB  = 18;
    localparam int SH_MSB  = 17;
    localparam int SH_LSB  = 12;
    localparam int FN_MSB  = 3;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational packer, decoded fields -> 32-bit instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  i_op_code,
    input  logic [3:0]  i_fn_code,
    input  logic [4:0]  i_reg1,
    input  logic [4:0]  i_reg2,
    input  logic [5:0]  i_shamt,
    input  logic [15:0] i_immediate,
    output logic [31:0] o_word
);

    logic [31:0] w_word;

    // Fields that do not belong to the instruction type stay zero in the word.
    always_comb begin
        w_word                 = '0;
        w_word[OP_MSB:OP_LSB]  = i_op_code;
        w_word[R1_MSB:R1_LSB]  = i_reg1;
        w_word[R2_MSB:R2_LSB]  = i_reg2;
        if (i_op_code == OP_RTYPE) begin
            w_word[SH_MSB:SH_LSB] = i_shamt;
            w_word[FN_MSB:FN_LSB] = i_fn_code;
        end else begin
            w_word[IMM_MSB:IMM_LSB] = i_immediate;
        end
    end

    assign o_word = w_word;

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Program loader; packs field sets and writes them to
//               instruction memory from a base address. Optional field
//               misuse checking is built when ENC_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_code,
    input  logic [3:0]        fn_code,
    input  logic [4:0]        reg1,
    input  logic [4:0]        reg2,
    input  logic [5:0]        shamt,
    input  logic [15:0]       immediate,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              enc_err
);

    enc_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_left;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_start_ok;

    instr_pack u_pack (
        .i_op_code   (op_code),
        .i_fn_code   (fn_code),
        .i_reg1      (reg1),
        .i_reg2      (reg2),
        .i_shamt     (shamt),
        .i_immediate (immediate),
        .o_word      (w_word)
    );

    // r_in_ready is only ever set in LOAD, so it alone qualifies an accept.
    assign w_accept   = in_valid & r_in_ready;
    assign w_start_ok = start & (r_state != ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_left      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    if (w_start_ok) begin
                        r_addr <= base_addr;
                        r_left <= count;
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= ST_LOAD;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_word;
                        r_addr      <= r_addr + 1'b1;
                        r_left      <= r_left - 1'b1;
                        // Final word: done and busy-fall line up with its write.
                        if (r_left == {{ADDR_W{1'b0}}, 1'b1}) begin
                            r_state    <= ST_FLUSH;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef ENC_CHECK_EN
    logic r_enc_err;
    logic w_misuse;

    always_comb begin
        w_misuse = 1'b0;
        if (op_code == OP_RTYPE)
            w_misuse = (immediate != '0);
        else
            w_misuse = (fn_code != '0) || (shamt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_enc_err <= 1'b0;
        else if (w_start_ok)
            r_enc_err <= 1'b0;
        else if (w_accept && w_misuse)
            r_enc_err <= 1'b1;
    end

    assign enc_err = r_enc_err;
`else
    assign enc_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder (vector table plus
//               directed sequences, write scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        op_code = '0;
    logic [3:0]        fn_code = '0;
    logic [4:0]        reg1 = '0;
    logic [4:0]        reg2 = '0;
    logic [5:0]        shamt = '0;
    logic [15:0]       immediate = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              enc_err;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .op_code(op_code), .fn_code(fn_code),
        .reg1(reg1), .reg2(reg2), .shamt(shamt), .immediate(immediate),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  fn;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [5:0]  sh;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    vec_t tbl[6];
    vec_t v_r, v_i, v_enc;
    int   checks = 0;
    int   errors = 0;
    int   n_wr = 0;
    int   n_done = 0;
    int   wr0, dn0;
    bit   allow_lone_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_wr++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%h data=%h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                m_e = sbq.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(m_e.addr));
                check("wr_data", mem_wdata, m_e.data);
                check("wr_done", 32'(done), 32'(m_e.last));
            end
        end else if (done === 1'b1 && !allow_lone_done) begin
            checks++;
            errors++;
            $display("FAIL lone_done actual=1 expected=0");
        end
        if (done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic [7:0] a, input logic last);
        bit ok = 1'b0;
        op_code   = v.op;
        fn_code   = v.fn;
        reg1      = v.r1;
        reg2      = v.r2;
        shamt     = v.sh;
        immediate = v.imm;
        in_valid  = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = in_ready;
            tick();
            if (ok) sbq.push_back('{addr: a, data: v.word, last: last});
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual in_ready=0 expected accept at addr %h", a);
        end
    endtask

    initial begin
        v_r   = '{op: 4'h0, fn: 4'h6, r1: 5'd3, r2: 5'd7, sh: 6'd2, imm: 16'h0, word: 32'h019C2006};
        v_i   = '{op: 4'hA, fn: 4'h0, r1: 5'd1, r2: 5'd2, sh: 6'd0, imm: 16'h3B06, word: 32'hA0883B06};
        v_enc = '{op: 4'h3, fn: 4'h0, r1: 5'd2, r2: 5'd4, sh: 6'd1, imm: 16'h0012, word: 32'h31100012};
        tbl[0] = v_r;
        tbl[1] = v_i;
        tbl[2] = '{op: 4'h0, fn: 4'hF, r1: 5'd31, r2: 5'd31, sh: 6'd63, imm: 16'hFFFF, word: 32'h0FFFF00F};
        tbl[3] = '{op: 4'hF, fn: 4'hF, r1: 5'd0, r2: 5'd0, sh: 6'd63, imm: 16'h0000, word: 32'hF0000000};
        tbl[4] = '{op: 4'h5, fn: 4'h0, r1: 5'd16, r2: 5'd9, sh: 6'd0, imm: 16'h8001, word: 32'h58248001};
        tbl[5] = '{op: 4'h0, fn: 4'h0, r1: 5'd1, r2: 5'd0, sh: 6'd0, imm: 16'h0000, word: 32'h00800000};

        // Reset with in_valid held high
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_enc_err", 32'(enc_err), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Single R-type word
        wr0 = n_wr; dn0 = n_done;
        do_start(8'h10, 9'd1);
        check("r_busy_rise", 32'(busy), 32'd1);
        check("r_in_ready", 32'(in_ready), 32'd1);
        send(v_r, 8'h10, 1'b1);
        check("r_busy_fall", 32'(busy), 32'd0);
        tick();
        tick();
        check("r_writes", 32'(n_wr - wr0), 32'd1);
        check("r_dones", 32'(n_done - dn0), 32'd1);

        // I-type burst across the address wrap
        wr0 = n_wr;
        do_start(8'hFE, 9'd3);
        send(v_i, 8'hFE, 1'b0);
        send(v_i, 8'hFF, 1'b0);
        send(v_i, 8'h00, 1'b1);
        tick();
        tick();
        check("burst_writes", 32'(n_wr - wr0), 32'd3);

        // Gapped handshake with a start pulse mid-run
        wr0 = n_wr; dn0 = n_done;
        do_start(8'h20, 9'd2);
        send(v_i, 8'h20, 1'b0);
        do_start(8'h80, 9'd5);
        check("gap_busy", 32'(busy), 32'd1);
        send(v_r, 8'h21, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        check("gap_writes", 32'(n_wr - wr0), 32'd2);
        check("gap_dones", 32'(n_done - dn0), 32'd1);
        check("gap_busy_end", 32'(busy), 32'd0);

        // Zero-length run
        wr0 = n_wr;
        allow_lone_done = 1'b1;
        do_start(8'h33, 9'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_in_ready", 32'(in_ready), 32'd0);
        tick();
        allow_lone_done = 1'b0;
        check("zero_done_fall", 32'(done), 32'd0);
        check("zero_writes", 32'(n_wr - wr0), 32'd0);

        // Vector table, back-to-back
        wr0 = n_wr;
        do_start(8'h40, 9'd6);
        for (int i = 0; i < 6; i++) send(tbl[i], 8'(8'h40 + i), (i == 5));
        tick();
        check("tbl_writes", 32'(n_wr - wr0), 32'd6);
`ifdef ENC_CHECK_EN
        check("tbl_enc_err", 32'(enc_err), 32'd1);
`else
        check("tbl_enc_err", 32'(enc_err), 32'd0);
`endif

        // Reset after two accepts of a four-word run
        do_start(8'h50, 9'd4);
        send(v_i, 8'h50, 1'b0);
        send(v_r, 8'h51, 1'b0);
        rst = 1'b1;
        send_fields_only();
        tick();
        rst = 1'b0;
        wr0 = n_wr; dn0 = n_done;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd0);
        check("mid_mem_addr", 32'(mem_addr), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        in_valid = 1'b0;
        check("mid_writes", 32'(n_wr - wr0), 32'd0);
        check("mid_dones", 32'(n_done - dn0), 32'd0);
        check("mid_enc_err", 32'(enc_err), 32'd0);

`ifdef ENC_CHECK_EN
        do_start(8'h60, 9'd1);
        check("enc_clear_on_start", 32'(enc_err), 32'd0);
        send(v_enc, 8'h60, 1'b1);
        tick();
        check("enc_set", 32'(enc_err), 32'd1);
        allow_lone_done = 1'b1;
        do_start(8'h61, 9'd0);
        tick();
        allow_lone_done = 1'b0;
        check("enc_cleared", 32'(enc_err), 32'd0);
`else
        do_start(8'h60, 9'd1);
        send(v_enc, 8'h60, 1'b1);
        tick();
        check("enc_tied_zero", 32'(enc_err), 32'd0);
`endif

        tick();
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic send_fields_only();
        op_code   = v_i.op;
        fn_code   = v_i.fn;
        reg1      = v_i.r1;
        reg2      = v_i.r2;
        shamt     = v_i.sh;
        immediate = v_i.imm;
        in_valid  = 1'b1;
    endtask

endmodule
`default_nettype wire
